// File: rtl/pq_sched_arbiter.sv
// Round-robin arbiter sharing one prio_q event heap among NREQ cores.
// Paces heap ops by ISSUE_GAP, tracks occupancy and returns dequeued events.
module pq_sched_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DWIDTH    = 16,
  parameter int unsigned HDEPTH    = 5,
  parameter int unsigned ISSUE_GAP = 1
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_enq,
  input  logic [NREQ-1:0]            req_deq,
  input  logic [NREQ*DWIDTH-1:0]     req_data,
  output logic [NREQ-1:0]            grant,
  output logic                       rsp_valid,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [DWIDTH-1:0]          rsp_data,
  output logic                       pq_enq,
  output logic                       pq_deq,
  output logic [DWIDTH-1:0]          pq_inp_data,
  input  logic [DWIDTH-1:0]          pq_out_data,
  input  logic [HDEPTH-1:0]          pq_count,
  output logic [HDEPTH-1:0]          occ,
  output logic                       full,
  output logic                       empty,
  output logic                       err_sync
);
  localparam int unsigned IW  = $clog2(NREQ);
  localparam int unsigned GW  = $clog2(ISSUE_GAP + 1);
  localparam int unsigned CAP = (1 << HDEPTH) - 1;

  typedef enum logic {S_IDLE = 1'b0, S_GAP = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HDEPTH-1:0] occ_q, occ_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]     rsp_id_q, rsp_id_d;
  logic [DWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic              op_prev_q, op_prev_d;
  logic              err_sync_q, err_sync_d;

  logic [NREQ-1:0]   elig;
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic              sel_enq;

  // First eligible core at or after rr_ptr; descending scan so the nearest wins.
  always_comb begin
    elig      = (req_enq & {NREQ{~full_q}}) | (req_deq & {NREQ{~empty_q}});
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (elig[IW'((int'(rr_ptr_q) + k) % int'(NREQ))]) begin
        sel_found = 1'b1;
        sel_idx   = IW'((int'(rr_ptr_q) + k) % int'(NREQ));
      end
    end
    sel_enq = req_enq[sel_idx] & ~full_q;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found && (ISSUE_GAP > 1)) begin
          state_d = S_GAP;
          gap_d   = GW'(ISSUE_GAP - 1);
        end
      end
      S_GAP: begin
        if (gap_q <= GW'(1)) begin
          state_d = S_IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gap_d   = '0;
      end
    endcase
  end

  // Grant and heap command are issued in the same cycle as the arbitration.
  always_comb begin
    grant       = '0;
    pq_enq      = 1'b0;
    pq_deq      = 1'b0;
    pq_inp_data = '0;
    if ((state_q == S_IDLE) && sel_found) begin
      grant[sel_idx] = 1'b1;
      if (sel_enq) begin
        pq_enq      = 1'b1;
        pq_inp_data = req_data[32'(sel_idx)*DWIDTH +: DWIDTH];
      end else begin
        pq_deq = 1'b1;
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (pq_enq) begin
      occ_d = occ_q + HDEPTH'(1);
    end else if (pq_deq) begin
      occ_d = occ_q - HDEPTH'(1);
    end
    full_d   = (occ_d == HDEPTH'(CAP));
    empty_d  = (occ_d == '0);
    rr_ptr_d = rr_ptr_q;
    if (pq_enq || pq_deq) begin
      rr_ptr_d = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + IW'(1);
    end
    rsp_valid_d = pq_deq;
    rsp_id_d    = pq_deq ? sel_idx : rsp_id_q;
    rsp_data_d  = pq_deq ? pq_out_data : rsp_data_q;
    op_prev_d   = pq_enq | pq_deq;
    // Heap count lags by one op, so compare only after an idle cycle.
    err_sync_d  = err_sync_q | (~op_prev_q & (occ_q != pq_count));
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      occ_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      op_prev_q   <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      occ_q       <= occ_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      op_prev_q   <= op_prev_d;
      err_sync_q  <= err_sync_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign occ       = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err_sync  = err_sync_q;

endmodule
